// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_pkg                                                      |
// | Brief   : ALU function codes, ALUOp and funct7 encodings, FSM states.  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Low eight codes follow funct3 so base and M ops decode by concatenation.
  typedef enum logic [4:0] {
    FN_ADD    = 5'd0,
    FN_SLL    = 5'd1,
    FN_SLT    = 5'd2,
    FN_SLTU   = 5'd3,
    FN_XOR    = 5'd4,
    FN_SRL    = 5'd5,
    FN_OR     = 5'd6,
    FN_AND    = 5'd7,
    FN_MUL    = 5'd8,
    FN_MULH   = 5'd9,
    FN_MULHSU = 5'd10,
    FN_MULHU  = 5'd11,
    FN_DIV    = 5'd12,
    FN_DIVU   = 5'd13,
    FN_REM    = 5'd14,
    FN_REMU   = 5'd15,
    FN_SUB    = 5'd16,
    FN_SRA    = 5'd17
  } alu_fn_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic alu_fn_e base_fn(input logic [2:0] f3);
    return alu_fn_e'({2'b00, f3});
  endfunction

  function automatic alu_fn_e md_fn(input logic [2:0] f3);
    return alu_fn_e'({2'b01, f3});
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_exec_unit_if                                             |
// | Brief   : Operation/result handshake bundle of the execute unit.       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_muldiv_iter                                              |
// | Brief   : Iterative shift-add multiplier / restoring divider, XLEN     |
// |           steps per op. Present only when ALU_MULDIV_EN is defined.    |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  alu_fn_e         fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  alu_fn_e           fn_q;
  logic              busy_q, div_q, neg_q, neg_rem_q, div0_q, ovf_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   m_q, a_q;

  logic              w_div, w_sa, w_sb, w_a_neg, w_b_neg, w_ovf, w_ge;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_diff, w_quot, w_rem;
  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;

  // Both engines run on magnitudes; signs are re-applied on the final step.
  assign w_div   = fn_i inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  assign w_sa    = fn_i inside {FN_MULH, FN_MULHSU, FN_DIV, FN_REM};
  assign w_sb    = fn_i inside {FN_MULH, FN_DIV, FN_REM};
  assign w_a_neg = w_sa & a_i[XLEN-1];
  assign w_b_neg = w_sb & b_i[XLEN-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;
  assign w_ovf   = w_sb & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);

  assign w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? m_q : '0)};
  assign w_mul_nxt = {w_mul_sum, acc_q[XLEN-1:1]};

  assign w_rem_sh  = acc_q[2*XLEN-1:XLEN-1];
  assign w_ge      = (w_rem_sh >= {1'b0, m_q});
  assign w_diff    = w_rem_sh[XLEN-1:0] - m_q;
  assign w_div_nxt = {(w_ge ? w_diff : w_rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], w_ge};

  assign w_acc_nxt = div_q ? w_div_nxt : w_mul_nxt;
  assign w_prod    = neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quot    = w_acc_nxt[XLEN-1:0];
  assign w_rem     = w_acc_nxt[2*XLEN-1:XLEN];

  assign done_o = busy_q && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_q      <= FN_MUL;
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      a_q       <= '0;
    end else if (start_i) begin
      fn_q      <= fn_i;
      busy_q    <= 1'b1;
      div_q     <= w_div;
      neg_q     <= w_a_neg ^ w_b_neg;
      neg_rem_q <= w_a_neg;
      div0_q    <= (b_i == '0);
      ovf_q     <= w_ovf;
      cnt_q     <= '0;
      acc_q     <= {{XLEN{1'b0}}, (w_div ? w_a_mag : w_b_mag)};
      m_q       <= w_div ? w_b_mag : w_a_mag;
      a_q       <= a_i;
    end else if (busy_q) begin
      acc_q <= w_acc_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  always_comb begin
    result_o = '0;
    case (fn_q)
      FN_MUL:                      result_o = w_prod[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: result_o = w_prod[2*XLEN-1:XLEN];
      FN_DIV:  result_o = div0_q ? '1 : (ovf_q ? a_q : (neg_q ? -w_quot : w_quot));
      FN_DIVU: result_o = div0_q ? '1 : w_quot;
      FN_REM:  result_o = div0_q ? a_q : (ovf_q ? '0 : (neg_rem_q ? -w_rem : w_rem));
      FN_REMU: result_o = div0_q ? a_q : w_rem;
      default: result_o = '0;
    endcase
  end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_exec_unit                                                |
// | Brief   : Registered RV32I execute stage: ALUOp decode, ALU, handshake |
// |           FSM. ALU_MULDIV_EN adds the iterative M extension.           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q;
  logic            zero_q, illegal_q;

  alu_fn_e         w_fn;
  logic            w_illegal, w_is_md, w_in_ready, w_load_base, w_load_md;
  logic            w_md_done;
  logic [XLEN-1:0] w_alu, w_base_res, w_md_result;
  logic [SHW-1:0]  w_shamt;

  assign w_shamt = bus.op_b[SHW-1:0];

  always_comb begin
    w_fn      = FN_ADD;
    w_illegal = 1'b0;
    w_is_md   = 1'b0;
    case (bus.alu_op)
      ALUOP_MEM:    w_fn = FN_ADD;
      ALUOP_BRANCH: w_fn = FN_SUB;
      ALUOP_RTYPE: begin
        case (bus.funct7)
          F7_BASE: w_fn = base_fn(bus.funct3);
          F7_ALT: begin
            if (bus.funct3 == 3'b000)      w_fn = FN_SUB;
            else if (bus.funct3 == 3'b101) w_fn = FN_SRA;
            else                           w_illegal = 1'b1;
          end
`ifdef ALU_MULDIV_EN
          F7_MULDIV: begin
            w_fn    = md_fn(bus.funct3);
            w_is_md = 1'b1;
          end
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings.
        w_fn = base_fn(bus.funct3);
        if (bus.funct3 == 3'b001) begin
          if (bus.funct7 != F7_BASE) w_illegal = 1'b1;
        end else if (bus.funct3 == 3'b101) begin
          if (bus.funct7 == F7_ALT)        w_fn = FN_SRA;
          else if (bus.funct7 != F7_BASE) w_illegal = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_fn)
      FN_ADD:  w_alu = bus.op_a + bus.op_b;
      FN_SUB:  w_alu = bus.op_a - bus.op_b;
      FN_SLL:  w_alu = bus.op_a << w_shamt;
      FN_SRL:  w_alu = bus.op_a >> w_shamt;
      FN_SRA:  w_alu = $signed(bus.op_a) >>> w_shamt;
      FN_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      FN_SLTU: w_alu = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      FN_XOR:  w_alu = bus.op_a ^ bus.op_b;
      FN_OR:   w_alu = bus.op_a | bus.op_b;
      FN_AND:  w_alu = bus.op_a & bus.op_b;
      default: w_alu = '0;
    endcase
  end

  assign w_base_res = w_illegal ? '0 : w_alu;

`ifdef ALU_MULDIV_EN
  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (bus.in_valid & w_in_ready & w_is_md),
    .fn_i     (w_fn),
    .a_i      (bus.op_a),
    .b_i      (bus.op_b),
    .done_o   (w_md_done),
    .result_o (w_md_result)
  );
`else
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  always_comb begin
    state_d    = state_q;
    w_in_ready = 1'b0;
    w_load_md  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) state_d = w_is_md ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (w_md_done) begin
          state_d   = ST_DONE;
          w_load_md = 1'b1;
        end
      end
      ST_DONE: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = w_is_md ? ST_BUSY : ST_DONE;
          else              state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    w_load_base = bus.in_valid & w_in_ready & ~w_is_md;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_load_base) begin
        result_q  <= w_base_res;
        zero_q    <= (w_base_res == '0);
        illegal_q <= w_illegal;
      end else if (w_load_md) begin
        result_q  <= w_md_result;
        zero_q    <= (w_md_result == '0);
        illegal_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_alu_exec_unit                                             |
// | Brief   : Scoreboard bench for alu_exec_unit; M-extension directed     |
// |           cases follow ALU_MULDIV_EN.                                  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_alu_exec_unit;

  localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();
  alu_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [31:0] r; logic ill; } exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rand_bp = 1'b0;
  logic forced_ready = 1'b1;

  function automatic logic [31:0] basic(input logic [2:0] f3, input bit arith,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return arith ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] muldiv(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a)); sb_ = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb_; return p[31:0];  end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            else return 32'(sa / sb_);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            else return 32'(sa % sb_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic ref_alu(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill);
    r = 32'd0; ill = 1'b0;
    if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else if (op == 2'b10) begin
      if (f7 == 7'h00) r = basic(f3, 1'b0, a, b);
      else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
      else if (f7 == 7'h20 && f3 == 3'd5) r = basic(f3, 1'b1, a, b);
      else if (f7 == 7'h01 && MD_EN) r = muldiv(f3, a, b);
      else ill = 1'b1;
    end else begin
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20) r = basic(f3, 1'b1, a, b);
      else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
      else r = basic(f3, 1'b0, a, b);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic eill, output int waits);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.op_a = a; bus.op_b = b;
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk); #1; waits++;
    end
    if (!bus.in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout got in_ready=0 exp in_ready=1");
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back(exp_t'{r: er, ill: eill});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 600) begin
      @(negedge clk); t++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout got pending=%0d exp pending=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output got r=%h exp none", bus.result);
        end else begin
          e = sb.pop_front();
          if (bus.result !== e.r || bus.illegal !== e.ill || bus.zero !== (e.r == 32'd0)) begin
            n_err++;
            $display("FAIL output got r=%h z=%b ill=%b exp r=%h z=%b ill=%b",
                     bus.result, bus.zero, bus.illegal, e.r, (e.r == 32'd0), e.ill);
          end
        end
      end
    end
  end

  initial begin
    #800000;
    n_err++;
    $display("FAIL watchdog got running exp finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int w0, w1, lat, seen;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, er;
    logic        eill;

    bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
    bus.op_a = 32'd0; bus.op_b = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.out_valid, bus.zero, bus.illegal, bus.in_ready, bus.result},
          {1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back R-type ADD/SUB with a free consumer.
    send(2'b10, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0, w0);
    check("base_latency", bus.out_valid, 1'b1);
    send(2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, w1);
    check("b2b_no_stall", w0 + w1, 0);
    drain();

    send(2'b11, 3'd5, 7'h20, 32'h80000000, 32'h00000404, 32'hF8000000, 1'b0, w0);
    send(2'b11, 3'd5, 7'h00, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, w0);
    send(2'b11, 3'd3, 7'h7F, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, w0);
    send(2'b11, 3'd1, 7'h20, 32'h00000001, 32'h00000404, 32'h00000000, 1'b1, w0);
    drain();

    // Held output under backpressure.
    forced_ready = 1'b0;
    @(negedge clk);
    send(2'b01, 3'd0, 7'h00, 32'd3, 32'd3, 32'd0, 1'b0, w0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {bus.out_valid, bus.zero, bus.in_ready, bus.result},
            {1'b1, 1'b1, 1'b0, 32'd0});
      @(negedge clk);
    end
    forced_ready = 1'b1;
    drain();

    send(2'b10, 3'd0, 7'h02, 32'd9, 32'd4, 32'd0, 1'b1, w0);
`ifndef ALU_MULDIV_EN
    send(2'b10, 3'd0, 7'h01, 32'd9, 32'd4, 32'd0, 1'b1, w0);
`endif
    drain();

    // Asynchronous reset with a result pending.
    forced_ready = 1'b0;
    @(negedge clk);
    send(2'b00, 3'd0, 7'h00, 32'd1, 32'd1, 32'd2, 1'b0, w0);
    check("pre_reset_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1 check("async_reset", {bus.out_valid, bus.in_ready, bus.result}, {1'b0, 1'b1, 32'd0});
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    forced_ready = 1'b1;
    @(negedge clk);

`ifdef ALU_MULDIV_EN
    send(2'b10, 3'd0, 7'h01, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, w0);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    check("mul_latency", lat, 33);
    drain();
    send(2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, w0);
    send(2'b10, 3'd4, 7'h01, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, w0);
    send(2'b10, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, w0);
    send(2'b10, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, w0);
    send(2'b10, 3'd5, 7'h01, 32'd100, 32'd7, 32'd14, 1'b0, w0);
    send(2'b10, 3'd6, 7'h01, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1'b0, w0);
    drain();

    send(2'b10, 3'd0, 7'h01, 32'd3, 32'd3, 32'd9, 1'b0, w0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("busy_reset_no_output", {seen, 31'd0, bus.in_ready}, {32'd0, 31'd0, 1'b1});
`endif

    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.alu_op = 2'($urandom); bus.funct3 = 3'($urandom); bus.funct7 = 7'($urandom);
        bus.op_a = $urandom; bus.op_b = $urandom;
        @(negedge clk);
      end
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = pick();
      b = pick();
      ref_alu(op, f3, f7, a, b, er, eill);
      send(op, f3, f7, a, b, er, eill, w0);
    end
    drain();
    rand_bp = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
